// File: rtl/dlsc_fifo_packet.sv
// dlsc_fifo_packet
// Single-clock FIFO with packet commit/abort. Words are written to storage as
// soon as they are pushed, but the reader only sees them once the packet that
// contains them is committed (push with wr_last). An uncommitted packet can be
// dropped in one cycle with wr_abort. With PACKET=0 every push commits at once
// and wr_abort is ignored.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   wr_push/wr_data     write one word (plus its wr_last flag)
//   wr_last             final word of a packet; commits the packet (PACKET=1)
//   wr_abort            discard every uncommitted word (PACKET=1)
//   wr_full             no free entries, counting uncommitted words
//   wr_almost_full      wr_free <= ALMOST_FULL
//   wr_free             free entries (ADDR+1 bits)
//   rd_pop              consume the head word
//   rd_data/rd_last     show-ahead head word, valid while !rd_empty
//   rd_empty            no committed words
//   rd_almost_empty     rd_count <= ALMOST_EMPTY
//   rd_count            committed words available (ADDR+1 bits)
module dlsc_fifo_packet #(
  parameter int DATA         = 8,
  parameter int ADDR         = 4,
  parameter int ALMOST_FULL  = 0,
  parameter int ALMOST_EMPTY = 0,
  parameter int PACKET       = 1,
  parameter bit BRAM         = ((2**ADDR)*(DATA+1)) >= 2048
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_push,
  input  logic [DATA-1:0] wr_data,
  input  logic            wr_last,
  input  logic            wr_abort,
  output logic            wr_full,
  output logic            wr_almost_full,
  output logic [ADDR:0]   wr_free,
  input  logic            rd_pop,
  output logic [DATA-1:0] rd_data,
  output logic            rd_last,
  output logic            rd_empty,
  output logic            rd_almost_empty,
  output logic [ADDR:0]   rd_count
);

  localparam int DEPTH = 2**ADDR;

  typedef logic [ADDR:0] ptr_t;
  typedef logic [DATA:0] word_t;  // {last, data}

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE_P   = ptr_t'(1);

  // NOTE: storage is deliberately not reset; emptiness is tracked purely by
  // the pointers, and a resettable array would block RAM inference.
  word_t mem [DEPTH];

  // wa: speculative write, ca: commit, ra: read. The extra MSB separates
  // full from empty when the low bits match.
  ptr_t  wa_q, wa_d, ca_q, ca_d, ra_q, ra_d;
  ptr_t  free_q, free_d, count_q, count_d;
  logic  full_q, full_d, afull_q, afull_d;
  logic  empty_q, empty_d, aempty_q, aempty_d;
  logic  abort_en, push_en;
  word_t wr_word, rd_word;

  assign wr_word = {wr_last, wr_data};

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    abort_en = (PACKET != 0) && wr_abort;
    push_en  = wr_push && !abort_en;  // abort wins over a same-cycle push
    wa_d     = wa_q;
    ca_d     = ca_q;
    ra_d     = ra_q;

    if (abort_en)     wa_d = ca_q;
    else if (push_en) wa_d = wa_q + ONE_P;

    if (push_en && (wr_last || PACKET == 0)) ca_d = wa_q + ONE_P;

    if (rd_pop) ra_d = ra_q + ONE_P;

    // Flags are computed from next-state pointers so the registered versions
    // line up with the pointers they describe.
    free_d   = DEPTH_P - (wa_d - ra_d);
    count_d  = ca_d - ra_d;
    full_d   = (free_d == '0);
    empty_d  = (count_d == '0);
    afull_d  = (32'(free_d) <= 32'(ALMOST_FULL));
    aempty_d = (32'(count_d) <= 32'(ALMOST_EMPTY));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa_q     <= '0;
      ca_q     <= '0;
      ra_q     <= '0;
      free_q   <= DEPTH_P;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= (ALMOST_FULL >= DEPTH);
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      wa_q     <= wa_d;
      ca_q     <= ca_d;
      ra_q     <= ra_d;
      free_q   <= free_d;
      count_q  <= count_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wa_q[ADDR-1:0]] <= wr_word;
  end

  generate
    if (BRAM) begin : g_bram
      // Registered read addressed by the next read pointer, so the head word
      // appears on the same cycle as with the asynchronous read. A word being
      // written into that slot on this edge is forwarded, since the RAM would
      // return the old contents.
      word_t rd_word_q, rd_word_d;

      always_comb begin
        rd_word_d = mem[ra_d[ADDR-1:0]];
        if (push_en && (wa_q[ADDR-1:0] == ra_d[ADDR-1:0])) rd_word_d = wr_word;
      end

      always_ff @(posedge clk) begin
        rd_word_q <= rd_word_d;
      end

      assign rd_word = rd_word_q;
    end else begin : g_lutram
      assign rd_word = mem[ra_q[ADDR-1:0]];
    end
  endgenerate

  assign rd_data         = rd_word[DATA-1:0];
  assign rd_last         = rd_word[DATA];
  assign wr_free         = free_q;
  assign wr_full         = full_q;
  assign wr_almost_full  = afull_q;
  assign rd_count        = count_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = aempty_q;

`ifndef SYNTHESIS
  // A push into a full FIFO is harmless when a pop frees a slot on the same
  // edge; anything else corrupts contents.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push_en && full_q && !rd_pop))
        else $error("dlsc_fifo_packet: overflow (push while full)");
      assert (!(rd_pop && empty_q))
        else $error("dlsc_fifo_packet: underflow (pop while empty)");
    end
  end
`endif

endmodule

// File: tb/tb_dlsc_fifo_packet.sv
// Testbench for dlsc_fifo_packet. Two instances share clk/rst:
//   u_pkt : packet mode, default thresholds, asynchronous-read storage
//   u_str : non-packet mode, ALMOST_FULL=2, ALMOST_EMPTY=3, registered-read storage
// The driver updates a queue-based reference model at each rising edge; the
// monitors compare flags/counts every falling edge and pop the scoreboard when
// the head word is consumed.
module tb_dlsc_fifo_packet;

  localparam int DEPTH = 16;

  logic clk, rst;

  logic       a_push, a_last, a_abort, a_pop;
  logic [7:0] a_data;
  logic       a_full, a_afull, a_empty, a_aempty, a_rd_last;
  logic [4:0] a_free, a_count;
  logic [7:0] a_rd_data;

  logic       b_push, b_last, b_abort, b_pop;
  logic [7:0] b_data;
  logic       b_full, b_afull, b_empty, b_aempty, b_rd_last;
  logic [4:0] b_free, b_count;
  logic [7:0] b_rd_data;

  dlsc_fifo_packet #(.DATA(8), .ADDR(4), .ALMOST_FULL(0), .ALMOST_EMPTY(0),
                     .PACKET(1), .BRAM(1'b0)) u_pkt (
    .clk(clk), .rst(rst),
    .wr_push(a_push), .wr_data(a_data), .wr_last(a_last), .wr_abort(a_abort),
    .wr_full(a_full), .wr_almost_full(a_afull), .wr_free(a_free),
    .rd_pop(a_pop), .rd_data(a_rd_data), .rd_last(a_rd_last),
    .rd_empty(a_empty), .rd_almost_empty(a_aempty), .rd_count(a_count)
  );

  dlsc_fifo_packet #(.DATA(8), .ADDR(4), .ALMOST_FULL(2), .ALMOST_EMPTY(3),
                     .PACKET(0), .BRAM(1'b1)) u_str (
    .clk(clk), .rst(rst),
    .wr_push(b_push), .wr_data(b_data), .wr_last(b_last), .wr_abort(b_abort),
    .wr_full(b_full), .wr_almost_full(b_afull), .wr_free(b_free),
    .rd_pop(b_pop), .rd_data(b_rd_data), .rd_last(b_rd_last),
    .rd_empty(b_empty), .rd_almost_empty(b_aempty), .rd_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed words visible to the reader (scoreboard) and
  // words pushed but not yet committed.
  logic [8:0] a_exp[$];
  logic [8:0] a_pend[$];
  logic [8:0] b_exp[$];

  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      a_exp.delete();
      a_pend.delete();
      b_exp.delete();
    end else begin
      if (a_abort) a_pend.delete();
      else if (a_push) begin
        a_pend.push_back({a_last, a_data});
        if (a_last) begin
          foreach (a_pend[i]) a_exp.push_back(a_pend[i]);
          a_pend.delete();
        end
      end
      if (b_push) b_exp.push_back({b_last, b_data});
    end
  endtask

  // One clock: model follows the edge, then inputs return to idle.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    {a_push, a_last, a_abort, a_pop} = '0;
    {b_push, b_last, b_abort, b_pop} = '0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin : mon_a
      int cnt, free;
      cnt  = a_exp.size();
      free = DEPTH - cnt - a_pend.size();
      check("a_rd_count", 32'(a_count), cnt);
      check("a_rd_empty", 32'(a_empty), 32'(cnt == 0));
      check("a_rd_almost_empty", 32'(a_aempty), 32'(cnt <= 0));
      check("a_wr_free", 32'(a_free), free);
      check("a_wr_full", 32'(a_full), 32'(free == 0));
      check("a_wr_almost_full", 32'(a_afull), 32'(free <= 0));
      if (a_pop && cnt > 0) begin
        check("a_rd_word", 32'({a_rd_last, a_rd_data}), 32'(a_exp[0]));
        void'(a_exp.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin : mon_b
      int cnt, free;
      cnt  = b_exp.size();
      free = DEPTH - cnt;
      check("b_rd_count", 32'(b_count), cnt);
      check("b_rd_empty", 32'(b_empty), 32'(cnt == 0));
      check("b_rd_almost_empty", 32'(b_aempty), 32'(cnt <= 3));
      check("b_wr_free", 32'(b_free), free);
      check("b_wr_full", 32'(b_full), 32'(free == 0));
      check("b_wr_almost_full", 32'(b_afull), 32'(free <= 2));
      if (b_pop && cnt > 0) begin
        check("b_rd_word", 32'({b_rd_last, b_rd_data}), 32'(b_exp[0]));
        void'(b_exp.pop_front());
      end
    end
  end

  task automatic a_words(input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      a_push = 1'b1;
      a_data = 8'($urandom);
      a_last = last_at_end && (i == n - 1);
      tick();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && (a_exp.size() > 0 || b_exp.size() > 0); k++) begin
      a_pop = (a_exp.size() > 0);
      b_pop = (b_exp.size() > 0);
      tick();
    end
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      int a_fr, b_fr;
      a_fr = DEPTH - a_exp.size() - a_pend.size();
      b_fr = DEPTH - b_exp.size();
      // A packet that cannot fit would deadlock; the writer must abort it.
      a_abort = (a_fr == 0 && a_exp.size() == 0) || ($urandom_range(0, 19) == 0);
      a_push  = (a_fr > 0) && ($urandom_range(0, 9) < 6);
      a_last  = ($urandom_range(0, 3) == 0);
      a_data  = 8'($urandom);
      a_pop   = (a_exp.size() > 0) && ($urandom_range(0, 1) == 1);
      b_push  = (b_fr > 0) && ($urandom_range(0, 9) < 6);
      b_last  = 1'($urandom_range(0, 1));
      b_abort = 1'($urandom_range(0, 1));
      b_data  = 8'($urandom);
      b_pop   = (b_exp.size() > 0) && ($urandom_range(0, 9) < 5);
      tick();
    end
  endtask

  initial begin
    {a_push, a_last, a_abort, a_pop} = '0;
    {b_push, b_last, b_abort, b_pop} = '0;
    a_data = '0;
    b_data = '0;
    rst    = 1'b1;
    tick();
    mon_en = 1'b1;
    rst    = 1'b1;
    tick();

    // 3-word packet, then read it out
    a_words(3, 1'b1);
    drain();

    // 5 uncommitted words then abort; a following 2-word packet
    a_words(5, 1'b0);
    a_abort = 1'b1;
    tick();
    a_words(2, 1'b1);
    drain();

    // abort beats a same-cycle committing push
    a_words(4, 1'b0);
    a_push  = 1'b1;
    a_last  = 1'b1;
    a_abort = 1'b1;
    a_data  = 8'($urandom);
    tick();
    tick();

    // fill to full as one packet, then push+pop at full
    a_words(16, 1'b1);
    a_push = 1'b1;
    a_last = 1'b1;
    a_pop  = 1'b1;
    a_data = 8'($urandom);
    tick();
    drain();

    // three full fills to exercise pointer wrap
    for (int r = 0; r < 3; r++) begin
      a_words(16, 1'b1);
      drain();
    end

    // non-packet instance: step up to full and back, with ignored aborts
    for (int i = 0; i < DEPTH; i++) begin
      b_push  = 1'b1;
      b_data  = 8'($urandom);
      b_last  = 1'($urandom_range(0, 1));
      b_abort = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    rand_phase(400);

    // reset mid-packet with 6 committed words
    drain();
    a_abort = 1'b1;
    tick();
    a_words(6, 1'b1);
    a_words(2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b_push = 1'b1;
      b_data = 8'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    tick();

    rand_phase(400);
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
